pow_seq: RTL

- Parametrised sequential integer exponentiation unit. Computes result = base^exp with square-and-multiply, one exponent bit per clock.
- Uses valid/ready handshakes on input and output, detects overflow, and optionally saturates.
- Next-generation power block for datapaths that need wider operands, correct exp=0 handling and back-pressure.

---
 rtl/pow_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pow_seq.sv
// Sequential unsigned exponentiation: result = base^exp by square-and-multiply,
// consuming one exponent bit per clock, with overflow detection and optional saturation.
module pow_seq #(
    parameter int BASE_W   = 5,
    parameter int EXP_W    = 3,
    parameter int OUT_W    = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BASE_W-1:0] base,
    input  logic [EXP_W-1:0]  exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  result,
    output logic              overflow,
    output logic              busy,
    output logic [1:0]        dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready/out_valid are decoded from state only, so neither depends on in_valid or out_ready.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [OUT_W-1:0]   sq_q, sq_d;
    logic [EXP_W-1:0]   e_q, e_d;
    logic               ovf_q, ovf_d;
    logic               sq_ovf_q, sq_ovf_d;
    logic [OUT_W-1:0]   result_q;
    logic               overflow_q;
    logic [2*OUT_W-1:0] prod_mul;
    logic [2*OUT_W-1:0] prod_sq;

    // sq_ovf only reaches ovf when that truncated square is actually multiplied in.
    always_comb begin
        prod_mul = {{OUT_W{1'b0}}, acc_q} * {{OUT_W{1'b0}}, sq_q};
        prod_sq  = {{OUT_W{1'b0}}, sq_q} * {{OUT_W{1'b0}}, sq_q};
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        if (e_q[0]) begin
            acc_d = prod_mul[OUT_W-1:0];
            ovf_d = ovf_q | sq_ovf_q | (|prod_mul[2*OUT_W-1:OUT_W]);
        end
        sq_d     = prod_sq[OUT_W-1:0];
        sq_ovf_d = sq_ovf_q | (|prod_sq[2*OUT_W-1:OUT_W]);
        e_d      = e_q >> 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            sq_q       <= '0;
            e_q        <= '0;
            ovf_q      <= 1'b0;
            sq_ovf_q   <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        acc_q    <= OUT_W'(1);
                        sq_q     <= OUT_W'(base);
                        e_q      <= exp;
                        ovf_q    <= 1'b0;
                        sq_ovf_q <= 1'b0;
                        if (exp == '0) begin
                            state_q    <= S_DONE;
                            result_q   <= OUT_W'(1);
                            overflow_q <= 1'b0;
                        end else begin
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_q    <= acc_d;
                    sq_q     <= sq_d;
                    e_q      <= e_d;
                    ovf_q    <= ovf_d;
                    sq_ovf_q <= sq_ovf_d;
                    if (e_d == '0) begin
                        state_q    <= S_DONE;
                        result_q   <= (ovf_d && SATURATE) ? '1 : acc_d;
                        overflow_q <= ovf_d;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign result      = result_q;
    assign overflow    = overflow_q;
    assign dbg_state_o = state_q;

    // A stalled result must not change until the consumer takes it.
    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(result) && $stable(overflow)));

    a_one_in_flight: assert property (@(posedge clk) disable iff (rst)
        !(in_ready && out_valid));

endmodule
